// File: rtl/mac_pkg.sv
// Shared types and widths for the multiply-accumulate frame block.
package mac_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/fpmult.sv
// 8x8 unsigned fixed-point multiplier, purely combinational, full 16-bit product.
module fpmult
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] prod
);

    assign prod = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_accumulator.sv
// Frame multiply-accumulate: one product register stage, one accumulate stage,
// and a result hold register drained over an output valid/ready handshake.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int CNT_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    // Both handshakes: a transfer happens on a rising edge where valid & ready.
    state_t              state, state_next;
    logic                run_q;
    logic [PROD_W-1:0]   mult_prod, p_prod;
    logic                p_last, p_vld;
    logic [ACC_W-1:0]    acc, acc_upd;
    logic [CNT_W-1:0]    cnt, cnt_upd;
    logic                ovf, ovf_upd;
    logic [ACC_W:0]      sum_w;
    logic                accept, close;

    fpmult u_fpmult (
        .a    (in_a),
        .b    (in_b),
        .prod (mult_prod)
    );

    // run_q keeps in_ready low during reset and releases it one edge later.
    assign in_ready  = run_q & (state == ACC) & ~(p_vld & p_last) & ~clr;
    assign accept    = in_valid & in_ready;
    assign close     = p_vld & p_last & ~clr;
    assign out_valid = (state == HOLD);

    always_comb begin
        sum_w   = {1'b0, acc} + (ACC_W+1)'(p_prod);
        acc_upd = sum_w[ACC_W-1:0];
        if (SAT && sum_w[ACC_W]) begin
            acc_upd = '1;
        end
        ovf_upd = ovf | sum_w[ACC_W];
        cnt_upd = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (close)     state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACC;
            default:                state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            run_q     <= 1'b0;
            p_prod    <= '0;
            p_last    <= 1'b0;
            p_vld     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_next;
            run_q <= 1'b1;
            p_vld <= accept;
            if (accept) begin
                p_prod <= mult_prod;
                p_last <= in_last;
            end
            // clr wins over accumulation, which also discards a last beat sitting in P.
            if (clr) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (p_vld) begin
                if (p_last) begin
                    out_sum   <= acc_upd;
                    out_count <= cnt_upd;
                    out_ovf   <= ovf_upd;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                end else begin
                    acc <= acc_upd;
                    cnt <= cnt_upd;
                    ovf <= ovf_upd;
                end
            end
        end
    end

endmodule
